// File: rtl/keypad_entry_buffer.sv
// Keypad entry buffer: synchronises and debounces scanner key presses, then
// edits a 4-digit BCD entry buffer (shift-in, backspace, clear) for display.
module keypad_entry_buffer #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter int WRAP_MODE       = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  key_code,
    input  logic        key_valid,
    output logic [15:0] digits,
    output logic [3:0]  digit_en,
    output logic [2:0]  digit_count,
    output logic        key_event,
    output logic [3:0]  event_code,
    output logic        overflow
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

    logic             valid_p0, valid_p1;
    logic [3:0]       code_p0, code_p1;
    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [3:0]       pc, pc_next;
    logic             fire;
    logic [15:0]      digits_next;
    logic [2:0]       count_next;
    logic             ovf_next;

    function automatic logic [3:0] en_mask(input logic [2:0] n);
        case (n)
            3'd0:    en_mask = 4'b0000;
            3'd1:    en_mask = 4'b0001;
            3'd2:    en_mask = 4'b0011;
            3'd3:    en_mask = 4'b0111;
            default: en_mask = 4'b1111;
        endcase
    endfunction

    // Stage p0/p1: two-flop synchronisers for the asynchronous scanner inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_p0 <= 1'b0;
            valid_p1 <= 1'b0;
            code_p0  <= 4'h0;
            code_p1  <= 4'h0;
        end else begin
            valid_p0 <= key_valid;
            valid_p1 <= valid_p0;
            code_p0  <= key_code;
            code_p1  <= code_p0;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        pc_next    = pc;
        fire       = 1'b0;
        case (state)
            IDLE: begin
                if (valid_p1) begin
                    pc_next    = code_p1;
                    cnt_next   = '0;
                    state_next = PRESS_WAIT;
                end
            end
            PRESS_WAIT: begin
                if (!valid_p1 || code_p1 != pc) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else if (cnt == CNT_LAST) begin
                    cnt_next   = '0;
                    fire       = 1'b1;
                    state_next = HELD;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            HELD: begin
                // Code changes while held are ignored: one event per press.
                if (!valid_p1) begin
                    cnt_next   = '0;
                    state_next = RELEASE_WAIT;
                end
            end
            default: begin
                if (valid_p1) begin
                    cnt_next   = '0;
                    state_next = HELD;
                end else if (cnt == CNT_LAST) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        digits_next = digits;
        count_next  = digit_count;
        ovf_next    = 1'b0;
        if (fire) begin
            if (pc <= 4'd9) begin
                if (digit_count == 3'd4) begin
                    ovf_next = 1'b1;
                    if (WRAP_MODE != 0)
                        digits_next = {digits[11:0], pc};
                end else begin
                    digits_next = {digits[11:0], pc};
                    count_next  = digit_count + 3'd1;
                end
            end else if (pc == 4'hB) begin
                if (digit_count != 3'd0) begin
                    digits_next = {4'h0, digits[15:4]};
                    count_next  = digit_count - 3'd1;
                end
            end else if (pc == 4'hC) begin
                digits_next = 16'h0000;
                count_next  = 3'd0;
            end
        end
    end

    // Stage p2: debounce state and registered buffer outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            pc          <= 4'h0;
            digits      <= 16'h0000;
            digit_count <= 3'd0;
            digit_en    <= 4'b0000;
            key_event   <= 1'b0;
            event_code  <= 4'h0;
            overflow    <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            pc          <= pc_next;
            digits      <= digits_next;
            digit_count <= count_next;
            digit_en    <= en_mask(count_next);
            key_event   <= fire;
            overflow    <= ovf_next;
            if (fire)
                event_code <= pc;
        end
    end

endmodule

// File: tb/tb_keypad_entry_buffer.sv
// Bench for keypad_entry_buffer: table of key presses with expected buffer
// states, a per-event scoreboard, and sequences for bounce, reset and long hold.
module tb_keypad_entry_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;

    logic [15:0] digits_w, digits_n, digits_l;
    logic [3:0]  en_w, en_n, en_l;
    logic [2:0]  cnt_w, cnt_n, cnt_l;
    logic        ev_w, ev_n, ev_l;
    logic [3:0]  ec_w, ec_n, ec_l;
    logic        ov_w, ov_n, ov_l;

    keypad_entry_buffer #(.DEBOUNCE_CYCLES(4), .CNT_W(20), .WRAP_MODE(1)) dut_w (
        .clk(clk), .rst(rst), .key_code(key_code), .key_valid(key_valid),
        .digits(digits_w), .digit_en(en_w), .digit_count(cnt_w),
        .key_event(ev_w), .event_code(ec_w), .overflow(ov_w));

    keypad_entry_buffer #(.DEBOUNCE_CYCLES(4), .CNT_W(20), .WRAP_MODE(0)) dut_n (
        .clk(clk), .rst(rst), .key_code(key_code), .key_valid(key_valid),
        .digits(digits_n), .digit_en(en_n), .digit_count(cnt_n),
        .key_event(ev_n), .event_code(ec_n), .overflow(ov_n));

    keypad_entry_buffer #(.DEBOUNCE_CYCLES(1000), .CNT_W(20), .WRAP_MODE(1)) dut_l (
        .clk(clk), .rst(rst), .key_code(key_code), .key_valid(key_valid),
        .digits(digits_l), .digit_en(en_l), .digit_count(cnt_l),
        .key_event(ev_l), .event_code(ec_l), .overflow(ov_l));

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  code;
        logic [15:0] digits;
        logic [2:0]  count;
        logic        ov;
    } exp_t;

    typedef struct {
        logic [3:0]  code;
        logic [15:0] dw;
        logic [2:0]  cw;
        logic [15:0] dn;
        logic [2:0]  cn;
        logic        ov;
    } row_t;

    exp_t qw[$];
    exp_t qn[$];
    exp_t ew, en_e;
    row_t tbl[15];

    int n_cmp = 0;
    int n_bad = 0;
    int l_events = 0;
    int maxcnt = 0;
    logic track = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] en_of(input logic [2:0] c);
        case (c)
            3'd0:    en_of = 4'h0;
            3'd1:    en_of = 4'h1;
            3'd2:    en_of = 4'h3;
            3'd3:    en_of = 4'h7;
            default: en_of = 4'hF;
        endcase
    endfunction

    // Scoreboard: compare every key_event against the oldest queued expectation
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (ev_w) begin
                    if (qw.size() == 0) check("w_unexpected_event", 32'(ec_w), 32'hFF);
                    else begin
                        ew = qw.pop_front();
                        check("w_event_code", 32'(ec_w), 32'(ew.code));
                        check("w_digits", 32'(digits_w), 32'(ew.digits));
                        check("w_count", 32'(cnt_w), 32'(ew.count));
                        check("w_digit_en", 32'(en_w), 32'(en_of(ew.count)));
                        check("w_overflow", 32'(ov_w), 32'(ew.ov));
                    end
                end else if (ov_w) check("w_stray_overflow", 32'(ov_w), 32'h0);
                if (ev_n) begin
                    if (qn.size() == 0) check("n_unexpected_event", 32'(ec_n), 32'hFF);
                    else begin
                        en_e = qn.pop_front();
                        check("n_event_code", 32'(ec_n), 32'(en_e.code));
                        check("n_digits", 32'(digits_n), 32'(en_e.digits));
                        check("n_count", 32'(cnt_n), 32'(en_e.count));
                        check("n_digit_en", 32'(en_n), 32'(en_of(en_e.count)));
                        check("n_overflow", 32'(ov_n), 32'(en_e.ov));
                    end
                end else if (ov_n) check("n_stray_overflow", 32'(ov_n), 32'h0);
                if (ev_l) l_events++;
                if (track && int'(dut_l.cnt) > maxcnt) maxcnt = int'(dut_l.cnt);
            end
        end
    end

    task automatic push_both(input logic [3:0] code, input logic [15:0] dw, input logic [2:0] cw,
                             input logic [15:0] dn, input logic [2:0] cn, input logic ov);
        qw.push_back('{code, dw, cw, ov});
        qn.push_back('{code, dn, cn, ov});
    endtask

    task automatic press(input logic [3:0] code, input int hold, input int rel);
        @(negedge clk);
        key_code  = code;
        key_valid = 1'b1;
        repeat (hold) @(negedge clk);
        key_valid = 1'b0;
        repeat (rel) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_digits"}, 32'({digits_w, digits_n}), 32'h0);
        check({tag, "_en_cnt"}, 32'({en_w, cnt_w, en_n, cnt_n}), 32'h0);
        check({tag, "_event"}, 32'({ev_w, ec_w, ov_w, ev_n, ec_n, ov_n}), 32'h0);
    endtask

    initial begin
        tbl[0]  = '{4'h1, 16'h0001, 3'd1, 16'h0001, 3'd1, 1'b0};
        tbl[1]  = '{4'h2, 16'h0012, 3'd2, 16'h0012, 3'd2, 1'b0};
        tbl[2]  = '{4'h3, 16'h0123, 3'd3, 16'h0123, 3'd3, 1'b0};
        tbl[3]  = '{4'h4, 16'h1234, 3'd4, 16'h1234, 3'd4, 1'b0};
        tbl[4]  = '{4'h7, 16'h2347, 3'd4, 16'h1234, 3'd4, 1'b1};
        tbl[5]  = '{4'hB, 16'h0234, 3'd3, 16'h0123, 3'd3, 1'b0};
        tbl[6]  = '{4'hB, 16'h0023, 3'd2, 16'h0012, 3'd2, 1'b0};
        tbl[7]  = '{4'hB, 16'h0002, 3'd1, 16'h0001, 3'd1, 1'b0};
        tbl[8]  = '{4'hB, 16'h0000, 3'd0, 16'h0000, 3'd0, 1'b0};
        tbl[9]  = '{4'hB, 16'h0000, 3'd0, 16'h0000, 3'd0, 1'b0};
        tbl[10] = '{4'h9, 16'h0009, 3'd1, 16'h0009, 3'd1, 1'b0};
        tbl[11] = '{4'h9, 16'h0099, 3'd2, 16'h0099, 3'd2, 1'b0};
        tbl[12] = '{4'hC, 16'h0000, 3'd0, 16'h0000, 3'd0, 1'b0};
        tbl[13] = '{4'hA, 16'h0000, 3'd0, 16'h0000, 3'd0, 1'b0};
        tbl[14] = '{4'hE, 16'h0000, 3'd0, 16'h0000, 3'd0, 1'b0};

        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            push_both(tbl[i].code, tbl[i].dw, tbl[i].cw, tbl[i].dn, tbl[i].cn, tbl[i].ov);
            press(tbl[i].code, 20, 20);
            check("tbl_pending_w", 32'(qw.size()), 32'h0);
            check("tbl_pending_n", 32'(qn.size()), 32'h0);
            check("tbl_digits_w", 32'(digits_w), 32'(tbl[i].dw));
            check("tbl_digits_n", 32'(digits_n), 32'(tbl[i].dn));
            check("tbl_en_w", 32'({en_w, cnt_w}), 32'({en_of(tbl[i].cw), tbl[i].cw}));
            check("tbl_event_code_w", 32'(ec_w), 32'(tbl[i].code));
        end

        // Press bounce: 2-cycle pulses never reach the debounce limit
        @(negedge clk);
        key_code = 4'h6;
        for (int i = 0; i < 30; i++) begin
            key_valid = ((i / 2) % 2 == 0);
            @(negedge clk);
        end
        push_both(4'h6, 16'h0006, 3'd1, 16'h0006, 3'd1, 1'b0);
        key_valid = 1'b1;
        repeat (20) @(negedge clk);
        check("bounce_press_pending", 32'(qw.size()), 32'h0);
        for (int i = 0; i < 30; i++) begin
            key_valid = ((i / 2) % 2 == 1);
            @(negedge clk);
        end
        key_valid = 1'b0;
        repeat (20) @(negedge clk);
        check("bounce_release_digits", 32'(digits_w), 32'h0006);

        // Code change while debouncing restarts on the new code
        push_both(4'h8, 16'h0068, 3'd2, 16'h0068, 3'd2, 1'b0);
        key_code  = 4'h3;
        key_valid = 1'b1;
        repeat (2) @(negedge clk);
        key_code = 4'h8;
        repeat (20) @(negedge clk);
        key_valid = 1'b0;
        repeat (20) @(negedge clk);
        check("code_change_pending", 32'(qw.size()), 32'h0);
        check("code_change_digits", 32'(digits_n), 32'h0068);

        // Asynchronous reset mid-debounce, key held across release
        key_code  = 4'h5;
        key_valid = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_zero("async_reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        push_both(4'h5, 16'h0005, 3'd1, 16'h0005, 3'd1, 1'b0);
        @(posedge clk);
        repeat (5) @(posedge clk);
        #1 check("latency_edge6", 32'(ev_w), 32'h0);
        @(posedge clk);
        #1 check("latency_edge7", 32'(ev_w), 32'h1);
        check("latency_digits", 32'(digits_w), 32'h0005);
        @(posedge clk);
        #1 check("latency_edge8", 32'(ev_w), 32'h0);
        repeat (12) @(negedge clk);
        key_valid = 1'b0;
        repeat (20) @(negedge clk);
        check("reset_single_event", 32'(qw.size()), 32'h0);

        // Long hold on the slow instance
        check("slow_no_early_event", 32'(l_events), 32'h0);
        maxcnt = 0;
        track  = 1'b1;
        push_both(4'h2, 16'h0052, 3'd2, 16'h0052, 3'd2, 1'b0);
        @(negedge clk);
        key_code  = 4'h2;
        key_valid = 1'b1;
        repeat (50000) @(negedge clk);
        key_valid = 1'b0;
        repeat (1100) @(negedge clk);
        track = 1'b0;
        check("long_events", 32'(l_events), 32'h1);
        check("long_cnt_max", 32'(maxcnt), 32'd999);
        check("long_digits", 32'(digits_l), 32'h0002);
        check("long_count", 32'({en_l, cnt_l}), 32'({4'h1, 3'd1}));
        check("long_state_idle", 32'(dut_l.cnt), 32'h0);

        check("final_pending_w", 32'(qw.size()), 32'h0);
        check("final_pending_n", 32'(qn.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
